// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Stopwatch controller for the counter / seven-segment display path.
// Three debounced button levels are edge-detected and drive an IDLE/RUN/PAUSE
// state machine that gates a prescaled up-counter wrapping at MAX. The value
// shown on the display is either the live count or a lap-hold snapshot.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   defined   : lap edge detector and snapshot register are built.
//   undefined : lap input ignored, held tied low, value is the live count.
//   The port list is the same in both builds.
//
// Parameters:
//   OUTPUTWIDTH  - width of the displayed count
//   DIVISIONBITS - prescaler width; one count step per 2^DIVISIONBITS RUN cycles
//   MAX          - last count value before wrapping to 0
//
// Ports:
//   clk        in   sole clock, rising edge
//   n_reset    in   asynchronous active-low reset
//   start_stop in   button level: IDLE->RUN, RUN<->PAUSE
//   lap        in   button level: toggle lap-hold snapshot (RUN/PAUSE only)
//   clear      in   button level: back to IDLE, everything zeroed
//   value      out  displayed count (snapshot when held, else live count)
//   running    out  high while in RUN
//   held       out  high while the lap snapshot is displayed
//   wrap       out  one-cycle pulse in the cycle the count first reads 0 after MAX
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int OUTPUTWIDTH  = 6,
    parameter int DIVISIONBITS = 0,
    parameter int MAX          = (2 ** OUTPUTWIDTH) - 1
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   start_stop,
    input  logic                   lap,
    input  logic                   clear,
    output logic [OUTPUTWIDTH-1:0] value,
    output logic                   running,
    output logic                   held,
    output logic                   wrap
);

    // A zero-width prescaler is not legal, so keep one bit and pin its
    // terminal value to 0: the prescaler then never leaves 0 and every RUN
    // cycle is a tick.
    localparam int PW = (DIVISIONBITS > 0) ? DIVISIONBITS : 1;
    localparam logic [PW-1:0]          PRE_LAST  = PW'((64'd1 << DIVISIONBITS) - 64'd1);
    localparam logic [PW-1:0]          PRE_ZERO  = PW'(32'd0);
    localparam logic [PW-1:0]          PRE_ONE   = PW'(32'd1);
    localparam logic [OUTPUTWIDTH-1:0] MAX_C     = OUTPUTWIDTH'(MAX);
    localparam logic [OUTPUTWIDTH-1:0] CNT_ZERO  = OUTPUTWIDTH'(32'd0);
    localparam logic [OUTPUTWIDTH-1:0] CNT_ONE   = OUTPUTWIDTH'(32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t                  state_r;
    logic                    running_r;
    logic                    wrap_r;
    logic [OUTPUTWIDTH-1:0]  count_r;
    logic [PW-1:0]           presc_r;
    logic                    ss_prev_r;
    logic                    clr_prev_r;

    logic                    ss_press_s;
    logic                    clr_press_s;
    logic                    run_step_s;
    logic                    tick_s;

    // Button press decode and prescaler tick. A press only counts when no
    // higher-priority press coincides; the edge that pauses or clears does not
    // advance the prescaler, so a resume continues exactly where it stopped.
    always_comb begin
        clr_press_s = clear & ~clr_prev_r;
        ss_press_s  = 1'b0;
        run_step_s  = 1'b0;
        tick_s      = 1'b0;
        if (!clr_press_s) begin
            ss_press_s = start_stop & ~ss_prev_r;
        end else begin
            ss_press_s = 1'b0;
        end
        if ((state_r == ST_RUN) && !clr_press_s && !ss_press_s) begin
            run_step_s = 1'b1;
            tick_s     = (presc_r == PRE_LAST);
        end else begin
            run_step_s = 1'b0;
            tick_s     = 1'b0;
        end
    end

    // Main state machine: state, prescaler, live count, wrap pulse, running.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r    <= ST_IDLE;
            running_r  <= 1'b0;
            wrap_r     <= 1'b0;
            count_r    <= CNT_ZERO;
            presc_r    <= PRE_ZERO;
            ss_prev_r  <= 1'b0;
            clr_prev_r <= 1'b0;
        end else begin
            ss_prev_r  <= start_stop;
            clr_prev_r <= clear;
            wrap_r     <= 1'b0;
            if (clr_press_s) begin
                state_r   <= ST_IDLE;
                running_r <= 1'b0;
                count_r   <= CNT_ZERO;
                presc_r   <= PRE_ZERO;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (ss_press_s) begin
                            state_r   <= ST_RUN;
                            running_r <= 1'b1;
                            presc_r   <= PRE_ZERO;
                        end
                    end
                    ST_RUN: begin
                        if (ss_press_s) begin
                            state_r   <= ST_PAUSE;
                            running_r <= 1'b0;
                        end else if (run_step_s) begin
                            if (tick_s) begin
                                presc_r <= PRE_ZERO;
                                if (count_r == MAX_C) begin
                                    count_r <= CNT_ZERO;
                                    wrap_r  <= 1'b1;
                                end else begin
                                    count_r <= count_r + CNT_ONE;
                                end
                            end else begin
                                presc_r <= presc_r + PRE_ONE;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (ss_press_s) begin
                            state_r   <= ST_RUN;
                            running_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        running_r <= 1'b0;
                        count_r   <= CNT_ZERO;
                        presc_r   <= PRE_ZERO;
                    end
                endcase
            end
        end
    end

    assign running = running_r;
    assign wrap    = wrap_r;

`ifdef STOPWATCH_LAP_EN
    logic                   lap_prev_r;
    logic                   held_r;
    logic [OUTPUTWIDTH-1:0] snap_r;
    logic                   lap_act_s;

    // Lap acts only when it is the sole winning press and a run is in progress.
    always_comb begin
        if ((lap & ~lap_prev_r) && !clr_press_s && !ss_press_s &&
            ((state_r == ST_RUN) || (state_r == ST_PAUSE))) begin
            lap_act_s = 1'b1;
        end else begin
            lap_act_s = 1'b0;
        end
    end

    // Lap-hold snapshot: first lap freezes the pre-edge count, second releases.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            lap_prev_r <= 1'b0;
            held_r     <= 1'b0;
            snap_r     <= CNT_ZERO;
        end else begin
            lap_prev_r <= lap;
            if (clr_press_s) begin
                held_r <= 1'b0;
                snap_r <= CNT_ZERO;
            end else if (lap_act_s) begin
                if (held_r) begin
                    held_r <= 1'b0;
                end else begin
                    held_r <= 1'b1;
                    snap_r <= count_r;
                end
            end
        end
    end

    assign held  = held_r;
    assign value = held_r ? snap_r : count_r;
`else
    logic unused_lap_s;

    assign unused_lap_s = lap;
    assign held         = 1'b0;
    assign value        = count_r;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Directed bench for stopwatch_ctrl with OUTPUTWIDTH=4, DIVISIONBITS=2, MAX=9.
// A vector table covers reset-and-start with start_stop held high; hand-written
// sequences cover wrap, pause/resume, lap hold, coincident presses and the
// asynchronous reset. Lap expectations follow STOPWATCH_LAP_EN.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    logic       clk;
    logic       n_reset;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic [3:0] value;
    logic       running;
    logic       held;
    logic       wrap;

    int n_cmp;
    int n_err;

    stopwatch_ctrl #(
        .OUTPUTWIDTH (4),
        .DIVISIONBITS(2),
        .MAX         (9)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .start_stop(start_stop),
        .lap       (lap),
        .clear     (clear),
        .value     (value),
        .running   (running),
        .held      (held),
        .wrap      (wrap)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         ss;
        bit         lp;
        bit         cl;
        logic [3:0] v;
        bit         r;
        bit         h;
        bit         w;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [3:0] ev, input logic er,
                       input logic eh, input logic ew);
        n_cmp++;
        if (value !== ev || running !== er || held !== eh || wrap !== ew) begin
            n_err++;
            $display("FAIL %s: got value=%0d running=%b held=%b wrap=%b, expected value=%0d running=%b held=%b wrap=%b",
                     nm, value, running, held, wrap, ev, er, eh, ew);
        end
    endtask

    // Drive button levels, take one rising edge, settle 1 unit past it.
    task automatic cyc(input bit ss, input bit lp, input bit cl);
        start_stop = ss;
        lap        = lp;
        clear      = cl;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] m_c;
    logic [1:0] m_p;
    logic       m_w;
    int         wrap_seen;
    int         wrap_iter;

    initial begin
        n_cmp = 0;
        n_err = 0;

        // start/hold table: press once, keep start_stop high, then release
        for (int i = 0; i < 11; i++) begin
            vecs[i].ss = (i < 10);
            vecs[i].lp = 1'b0;
            vecs[i].cl = 1'b0;
            vecs[i].r  = 1'b1;
            vecs[i].h  = 1'b0;
            vecs[i].w  = 1'b0;
        end
        vecs[0].v = 4'd0;  vecs[1].v = 4'd0;  vecs[2].v = 4'd0;  vecs[3].v = 4'd0;
        vecs[4].v = 4'd1;  vecs[5].v = 4'd1;  vecs[6].v = 4'd1;  vecs[7].v = 4'd1;
        vecs[8].v = 4'd2;  vecs[9].v = 4'd2;  vecs[10].v = 4'd2;

        // ---- reset ----
        n_reset    = 1'b0;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        #12;
        chk("reset_state", 4'd0, 1'b0, 1'b0, 1'b0);
        n_reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        chk("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0);

        // ---- start and held start_stop (table) ----
        for (int i = 0; i < 11; i++) begin
            cyc(vecs[i].ss, vecs[i].lp, vecs[i].cl);
            chk($sformatf("start_vec%0d", i), vecs[i].v, vecs[i].r, vecs[i].h, vecs[i].w);
        end

        // ---- wrap: 40 more RUN edges from count 2, prescaler 2 ----
        m_c       = 4'd2;
        m_p       = 2'd2;
        wrap_seen = 0;
        wrap_iter = -1;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            m_w = 1'b0;
            if (m_p == 2'd3) begin
                m_p = 2'd0;
                if (m_c == 4'd9) begin
                    m_c = 4'd0;
                    m_w = 1'b1;
                end else begin
                    m_c = m_c + 4'd1;
                end
            end else begin
                m_p = m_p + 2'd1;
            end
            chk($sformatf("wrap_run%0d", i), m_c, 1'b1, 1'b0, m_w);
            if (wrap === 1'b1) begin
                wrap_seen++;
                wrap_iter = i;
            end
        end
        n_cmp++;
        if (wrap_seen != 1 || wrap_iter != 29) begin
            n_err++;
            $display("FAIL wrap_pulse: got %0d pulses at edge %0d, expected 1 pulse at edge 29",
                     wrap_seen, wrap_iter);
        end

        cyc(1'b0, 1'b0, 1'b1);
        chk("clear_from_run", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // ---- pause and resume ----
        cyc(1'b1, 1'b0, 1'b0);
        chk("restart", 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("run_to_3", 4'd3, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("pause", 4'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk($sformatf("paused%0d", i), 4'd3, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("resume", 4'd3, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("resume_edge1", 4'd3, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("resume_edge2", 4'd4, 1'b1, 1'b0, 1'b0);

        // ---- lap hold ----
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("run_to_5", 4'd5, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("lap_take", 4'd5, 1'b1, LAP_ON, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("lap_hold_live6", LAP_ON ? 4'd5 : 4'd6, 1'b1, LAP_ON, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("lap_hold_live7", LAP_ON ? 4'd5 : 4'd7, 1'b1, LAP_ON, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("lap_release", 4'd7, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("lap_level_held", 4'd7, 1'b1, 1'b0, 1'b0);

        // ---- coincident presses, lap in IDLE ----
        cyc(1'b1, 1'b0, 1'b1);
        chk("clear_beats_ss", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("idle_stays", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("lap_in_idle", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // ---- asynchronous reset mid-RUN ----
        cyc(1'b1, 1'b0, 1'b0);
        chk("start_again", 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("run_to_6", 4'd6, 1'b1, 1'b0, 1'b0);
        #3;
        n_reset = 1'b0;
        #1;
        chk("async_reset_now", 4'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_held", 4'd0, 1'b0, 1'b0, 1'b0);
        #3;
        n_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk($sformatf("post_reset%0d", i), 4'd0, 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Stopwatch controller for the counter/seven-segment display path. It takes three debounced push-button levels (start/stop, lap, clear) and runs an IDLE/RUN/PAUSE state machine. It gates a prescaled up-counter that wraps at `MAX`, and drives the value presented to the seven-segment decoder, with an optional lap-hold snapshot.

## Interface
Parameters:
- `OUTPUTWIDTH`, default 6: width of the displayed count.
- `DIVISIONBITS`, default 0: prescaler width. One count step takes 2^DIVISIONBITS RUN cycles; 0 means step every RUN cycle.
- `MAX`, default (2**OUTPUTWIDTH)-1: last count value before wrap to 0. Must be ≤ (2**OUTPUTWIDTH)-1.

Ports:
- `clk`  in  1  sole clock; all state changes on posedge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `start_stop`  in  1  debounced, clk-synchronous button level.
- `lap`  in  1  debounced, clk-synchronous button level.
- `clear`  in  1  debounced, clk-synchronous button level.
- `value`  out  OUTPUTWIDTH  displayed count: snapshot when `held`, else live count.
- `running`  out  1  high while state is RUN.
- `held`  out  1  high while the lap snapshot is displayed.
- `wrap`  out  1  one-cycle pulse after the count wraps MAX→0.

## Operation
- **Edge detection.** Each button has a registered previous value, reset to 0. A press is `level & ~prev`. A held-high level produces exactly one press.
- **States.** IDLE (reset state), RUN, PAUSE.
- **Priority** when presses coincide: clear > start_stop > lap. Only the highest-priority press acts on that edge.
- **Clear press**, from any state: go to IDLE, and set count, prescaler, snapshot and `held` to 0.
- **start_stop press:**
  - IDLE→RUN, with prescaler cleared to 0.
  - RUN→PAUSE.
  - PAUSE→RUN. The prescaler is retained, so partial steps are not lost.
- **Prescaler.** Increments only in RUN. `tick` = RUN and prescaler == 2^DIVISIONBITS−1, after which the prescaler rolls to 0. With DIVISIONBITS=0, `tick` = RUN.
- **Count.** On `tick`, count == MAX → 0 and `wrap` is set; otherwise count+1. With no `tick`, the count holds.
- **Lap press**, RUN or PAUSE only (ignored in IDLE):
  - If `held`=0: snapshot ← current count (the pre-edge value) and `held` ← 1.
  - If `held`=1: `held` ← 0.
  - The live count is unaffected either way.
- A start_stop press does not change `held`.

## Timing
- Reset values: state IDLE; `value`, `running`, `held`, `wrap`, count, prescaler, snapshot and button history all 0. Reset takes effect asynchronously; outputs read 0 without a clock edge.
- Button-to-state latency: state updates on the first posedge at which the button is sampled high. `running` reflects it in the following cycle.
- First increment after IDLE→RUN comes on the 2^DIVISIONBITS-th RUN edge.
- `wrap` is registered. It is high for exactly the cycle in which count first reads 0 after MAX, and low on all other cycles, including after a clear.
- `value` is a combinational mux of registers: no added latency.
- Reset or clear mid-RUN abandons the partial prescaler count.

## Configuration
- `STOPWATCH_LAP_EN` defined: lap snapshot logic is present as described above.
- `STOPWATCH_LAP_EN` undefined:
  - the `lap` input is ignored;
  - no snapshot register or lap edge detector is built;
  - `held` is tied to 0;
  - `value` is always the live count.
- The port list is identical in both builds.

## Test plan
All scenarios use OUTPUTWIDTH=4, DIVISIONBITS=2, MAX=9.
- **Reset and start.** Reset, then a start_stop press → `running`=1 next cycle; `value`=1 after 4 RUN edges and 2 after 8. Holding start_stop high for 10 cycles causes a single transition.
- **Wrap.** Run 40 RUN edges → `value` goes 9→0, with `wrap` high for exactly one cycle coincident with `value`=0.
- **Pause and resume.** Press start_stop at `value`=3 with prescaler=2 → PAUSE, and `value` stays 3 for 20 cycles. Press again → RUN; `value`=4 after 2 RUN edges.
- **Lap hold.** Lap at `value`=5 → `held`=1 and `value` stays 5 while the live count advances. A second lap at live 7 → `held`=0 and `value`=7. Without `STOPWATCH_LAP_EN`: `held` stays 0 and `value` tracks the live count.
- **Simultaneous presses.** Clear + start_stop on the same edge in RUN → IDLE, `value`=0, `running`=0. Lap in IDLE → no effect.
- **Async reset.** Assert `n_reset` mid-RUN at `value`=6 between clock edges → all outputs 0 immediately. After release, state is IDLE and `value` stays 0.
